// File: rtl/evm_core_param.sv
// Parametrised EVM voting core: per-voter lockout, entry timeout, saturating tallies, winner/tie scan.
// Vote_ack follows the button edge by 2 cycles; result_valid rises NUM_CAND cycles after entering SCAN.
module evm_core_param #(
  parameter int NUM_CAND    = 4,
  parameter int UID_W       = 6,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000,
  localparam int SEL_W      = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [UID_W-1:0]    uid,
  input  logic                enter,
  input  logic [NUM_CAND-1:0] cand_btn,
  input  logic [SEL_W-1:0]    res_sel,
  output logic                busy,
  output logic                vote_ack,
  output logic                reject,
  output logic                timeout,
  output logic [CNT_W-1:0]    sel_count,
  output logic [CNT_W-1:0]    total_votes,
  output logic [SEL_W-1:0]    winner,
  output logic                tie,
  output logic                result_valid
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CAND - 1);
  localparam logic [SEL_W:0]   NC_EXT   = (SEL_W + 1)'(NUM_CAND);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_COMMIT, S_SCAN, S_SHOW} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  state_t               state_q, state_d;
  logic                 enter_prev_q, enter_prev_d;
  logic [NUM_CAND-1:0]  btn_prev_q, btn_prev_d;
  logic [UID_W-1:0]     uid_lat_q, uid_lat_d;
  logic [SEL_W-1:0]     cand_lat_q, cand_lat_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  cnt_t                 tally_q [NUM_CAND];
  cnt_t                 tally_d [NUM_CAND];
  cnt_t                 total_q, total_d;
  logic [2**UID_W-1:0]  voted_q, voted_d;
  logic [SEL_W-1:0]     scan_idx_q, scan_idx_d;
  cnt_t                 max_q, max_d;
  logic [SEL_W-1:0]     winner_q, winner_d;
  logic                 tie_q, tie_d;
  logic                 result_valid_q, result_valid_d;
  logic                 busy_q, busy_d;
  logic                 vote_ack_q, vote_ack_d;
  logic                 reject_q, reject_d;
  logic                 timeout_q, timeout_d;
  cnt_t                 sel_count_q, sel_count_d;

  logic                 enter_rise;
  logic [NUM_CAND-1:0]  btn_rise;
  logic [4:0]           n_rise;
  logic [SEL_W-1:0]     rise_idx;
  cnt_t                 scan_val;

  always_comb begin
    enter_rise = enter & ~enter_prev_q;
    btn_rise   = cand_btn & ~btn_prev_q;
    n_rise     = '0;
    rise_idx   = '0;
    // Descending walk leaves the lowest pressed index in rise_idx
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (btn_rise[i]) begin
        n_rise   = n_rise + 5'd1;
        rise_idx = SEL_W'(i);
      end
    end
    scan_val = tally_q[scan_idx_q];
  end

  always_comb begin
    state_d        = state_q;
    enter_prev_d   = enter;
    btn_prev_d     = cand_btn;
    uid_lat_d      = uid_lat_q;
    cand_lat_d     = cand_lat_q;
    tmo_cnt_d      = tmo_cnt_q;
    tally_d        = tally_q;
    total_d        = total_q;
    voted_d        = voted_q;
    scan_idx_d     = scan_idx_q;
    max_d          = max_q;
    winner_d       = winner_q;
    tie_d          = tie_q;
    result_valid_d = result_valid_q;
    vote_ack_d     = 1'b0;
    reject_d       = 1'b0;
    timeout_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode) begin
          state_d        = S_SCAN;
          scan_idx_d     = '0;
          result_valid_d = 1'b0;
        end else if (enter_rise) begin
          if (voted_q[uid]) begin
            reject_d = 1'b1;
          end else begin
            uid_lat_d = uid;
            tmo_cnt_d = '0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mode) begin
          state_d        = S_SCAN;
          scan_idx_d     = '0;
          result_valid_d = 1'b0;
        end else if (n_rise == 5'd1) begin
          cand_lat_d = rise_idx;
          state_d    = S_COMMIT;
        end else if (n_rise > 5'd1) begin
          reject_d = 1'b1;
          state_d  = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        if (tally_q[cand_lat_q] != '1) tally_d[cand_lat_q] = tally_q[cand_lat_q] + 1'b1;
        if (total_q != '1) total_d = total_q + 1'b1;
        voted_d[uid_lat_q] = 1'b1;
        vote_ack_d         = 1'b1;
        state_d            = S_IDLE;
      end
      S_SCAN: begin
        if (!mode) begin
          state_d        = S_IDLE;
          result_valid_d = 1'b0;
        end else begin
          // Index 0 seeds the running max; later equal tallies only raise tie
          if (scan_idx_q == '0 || scan_val > max_q) begin
            max_d    = scan_val;
            winner_d = scan_idx_q;
            tie_d    = 1'b0;
          end else if (scan_val == max_q) begin
            tie_d = 1'b1;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_d        = S_SHOW;
            result_valid_d = 1'b1;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (!mode) begin
          state_d        = S_IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_WAIT) || (state_d == S_COMMIT) || (state_d == S_SCAN);
    sel_count_d = '0;
    if (state_q == S_SHOW && mode && ({1'b0, res_sel} < NC_EXT)) sel_count_d = tally_q[res_sel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      enter_prev_q   <= 1'b0;
      btn_prev_q     <= '0;
      uid_lat_q      <= '0;
      cand_lat_q     <= '0;
      tmo_cnt_q      <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q        <= '0;
      voted_q        <= '0;
      scan_idx_q     <= '0;
      max_q          <= '0;
      winner_q       <= '0;
      tie_q          <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      vote_ack_q     <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
      sel_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      enter_prev_q   <= enter_prev_d;
      btn_prev_q     <= btn_prev_d;
      uid_lat_q      <= uid_lat_d;
      cand_lat_q     <= cand_lat_d;
      tmo_cnt_q      <= tmo_cnt_d;
      tally_q        <= tally_d;
      total_q        <= total_d;
      voted_q        <= voted_d;
      scan_idx_q     <= scan_idx_d;
      max_q          <= max_d;
      winner_q       <= winner_d;
      tie_q          <= tie_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      vote_ack_q     <= vote_ack_d;
      reject_q       <= reject_d;
      timeout_q      <= timeout_d;
      sel_count_q    <= sel_count_d;
    end
  end

  assign busy         = busy_q;
  assign vote_ack     = vote_ack_q;
  assign reject       = reject_q;
  assign timeout      = timeout_q;
  assign sel_count    = sel_count_q;
  assign total_votes  = total_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_evm_core_param.sv
// Scoreboarded bench for evm_core_param: stimulus pushes expected pulses/results, a negedge monitor pops and compares.
module tb_evm_core_param;
  localparam int NC   = 4;
  localparam int UW   = 6;
  localparam int CW   = 3;
  localparam int TO   = 20;
  localparam int CMAX = (1 << CW) - 1;
  localparam int K_ACK = 0, K_REJ = 1, K_TMO = 2, K_RES = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic [UW-1:0] uid = '0;
  logic          enter = 1'b0;
  logic [NC-1:0] cand_btn = '0;
  logic [1:0]    res_sel = '0;
  logic          busy, vote_ack, reject, timeout, tie, result_valid;
  logic [CW-1:0] sel_count, total_votes;
  logic [1:0]    winner;

  evm_core_param #(.NUM_CAND(NC), .UID_W(UW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .mode(mode), .uid(uid), .enter(enter),
    .cand_btn(cand_btn), .res_sel(res_sel), .busy(busy), .vote_ack(vote_ack),
    .reject(reject), .timeout(timeout), .sel_count(sel_count),
    .total_votes(total_votes), .winner(winner), .tie(tie), .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; int v1; int v2; } ev_t;
  ev_t sbq[$];

  int n_checks = 0;
  int n_err = 0;

  int  m_tally [NC];
  bit  m_voted [2**UW];
  int  m_total;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int v1, input int v2);
    ev_t e;
    e.kind = kind; e.cyc = c; e.v1 = v1; e.v2 = v2;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
    for (int i = 0; i < 2**UW; i++) m_voted[i] = 1'b0;
    m_total = 0;
  endtask

  function automatic void exp_result(output int w, output int t);
    int mx = -1;
    int n  = 0;
    w = 0;
    for (int i = 0; i < NC; i++) if (m_tally[i] > mx) begin mx = m_tally[i]; w = i; end
    for (int i = 0; i < NC; i++) if (m_tally[i] == mx) n++;
    t = (n > 1) ? 1 : 0;
  endfunction

  // Monitor: every pulse or result_valid rise must match the head of the scoreboard
  ev_t mon_e;
  int  mon_kind;
  bit  rv_prev = 1'b0;
  always @(negedge clock) begin
    if (vote_ack || reject || timeout) begin
      mon_kind = vote_ack ? K_ACK : (reject ? K_REJ : K_TMO);
      if (sbq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", mon_kind, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind", mon_kind, mon_e.kind);
        chk("pulse_cycle", cyc, mon_e.cyc);
        if (mon_kind == K_ACK) chk("ack_total_votes", int'(total_votes), mon_e.v1);
      end
    end
    if (result_valid && !rv_prev) begin
      if (sbq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_result: got result_valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("result_kind", K_RES, mon_e.kind);
        chk("result_cycle", cyc, mon_e.cyc);
        chk("winner", int'(winner), mon_e.v1);
        chk("tie", int'(tie), mon_e.v2);
      end
    end
    rv_prev = result_valid;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_vote_ack"}, int'(vote_ack), 0);
    chk({tag, "_reject"}, int'(reject), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_sel_count"}, int'(sel_count), 0);
    chk({tag, "_total"}, int'(total_votes), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_tie"}, int'(tie), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; mode = 1'b0; enter = 1'b0; cand_btn = '0;
    #2;
    check_all_zero("reset");
    tick(2);
    reset = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic enter_uid(input int u, output bit ok);
    uid = UW'(u);
    enter = 1'b1;
    ok = !m_voted[u];
    if (!ok) push(K_REJ, cyc + 1, 0, 0);
    tick(1);
    enter = 1'b0;
    chk("busy_after_enter", int'(busy), ok ? 1 : 0);
  endtask

  task automatic vote(input int u, input logic [NC-1:0] btn);
    bit ok;
    int n;
    int c;
    enter_uid(u, ok);
    if (!ok) begin tick(2); return; end
    n = $countones(btn);
    c = 0;
    for (int i = NC - 1; i >= 0; i--) if (btn[i]) c = i;
    cand_btn = btn;
    if (n == 1) begin
      m_tally[c] = (m_tally[c] < CMAX) ? m_tally[c] + 1 : CMAX;
      m_total    = (m_total < CMAX) ? m_total + 1 : CMAX;
      m_voted[u] = 1'b1;
      push(K_ACK, cyc + 2, m_total, 0);
      tick(3);
    end else if (n > 1) begin
      push(K_REJ, cyc + 1, 0, 0);
      tick(2);
    end else begin
      push(K_TMO, cyc + TO, 0, 0);
      tick(TO + 2);
    end
    cand_btn = '0;
    tick(2);
  endtask

  task automatic show_results(input bit abort_first, input int u);
    bit ok;
    int w;
    int t;
    if (abort_first) enter_uid(u, ok);
    exp_result(w, t);
    mode = 1'b1;
    push(K_RES, cyc + 1 + NC, w, t);
    tick(1);
    chk("busy_in_scan", int'(busy), 1);
    chk("rv_cleared_in_scan", int'(result_valid), 0);
    tick(NC + 1);
    chk("busy_in_show", int'(busy), 0);
    chk("rv_in_show", int'(result_valid), 1);
    for (int s = 0; s < NC; s++) begin
      res_sel = 2'(s);
      tick(1);
      chk($sformatf("sel_count_%0d", s), int'(sel_count), m_tally[s]);
    end
    enter = 1'b1;
    cand_btn = NC'(1 << $urandom_range(0, NC - 1));
    tick(2);
    enter = 1'b0;
    cand_btn = '0;
    chk("show_ignores_input", int'(total_votes), m_total);
    mode = 1'b0;
    tick(1);
    chk("rv_after_mode0", int'(result_valid), 0);
    chk("sel_count_mode0", int'(sel_count), 0);
    tick(2);
  endtask

  initial begin
    int r;
    int u;
    int b0;
    int b1;
    bit ok;
    model_clear();
    tick(1);
    do_reset();

    vote(5, 4'b0010);
    vote(5, 4'b0100);
    vote(6, 4'b1000);
    vote(7, 4'b0011);
    vote(7, 4'b0001);
    vote(9, 4'b0000);
    vote(9, 4'b0010);
    show_results(1'b0, 0);

    do_reset();
    for (int i = 10; i < 12; i++) vote(i, 4'b0001);
    for (int i = 12; i < 15; i++) vote(i, 4'b0010);
    for (int i = 15; i < 18; i++) vote(i, 4'b0100);
    show_results(1'b0, 0);

    for (int it = 0; it < 40; it++) begin
      u = $urandom_range(0, 31);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        vote(u, NC'(1 << $urandom_range(0, NC - 1)));
      end else if (r < 75) begin
        b0 = $urandom_range(0, NC - 1);
        b1 = (b0 + $urandom_range(1, NC - 1)) % NC;
        vote(u, NC'((1 << b0) | (1 << b1)));
      end else if (r < 85) begin
        vote(u, '0);
      end else begin
        show_results(1'b1, u);
      end
      if (it % 10 == 9) show_results(1'b0, 0);
    end

    for (int i = 40; i < 48; i++) vote(i, 4'b0001);
    show_results(1'b0, 0);

    enter_uid(48, ok);
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_wait");
    tick(2);
    reset = 1'b0;
    model_clear();
    tick(2);
    vote(5, 4'b0001);
    show_results(1'b0, 0);

    tick(5);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/evm_core_param.md
Name: evm_core_param

Overview:
- Parametrised voting core for the EVM top level. Generalises the fixed three/four-candidate control unit to NUM_CAND candidates and a 2^UID_W voter roll.
- Adds per-voter duplicate-vote lockout, a vote-entry timeout, saturating tallies, and a sequential winner/tie scan in result mode.
- Sits between the debounced board inputs (switches/buttons) and the LED/VIO observation outputs.

Parameters:
- NUM_CAND, 4: number of candidates; range 2..16.
- UID_W, 6: voter ID width; voter roll holds 2^UID_W entries.
- CNT_W, 8: width of each per-candidate tally and of the total.
- TIMEOUT_CYC, 1000: cycles allowed in WAIT_VOTE before abort; must be >= 2.

Ports:
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- mode, input, 1: 0 = voting, 1 = result.
- uid, input, UID_W: voter ID, sampled on the enter pulse.
- enter, input, 1: voter-submit strobe; level input, rising edge detected internally.
- cand_btn, input, NUM_CAND: candidate buttons; levels, rising edges detected internally.
- res_sel, input, clog2(NUM_CAND): candidate index to display in result mode.
- busy, output, 1: high while a voter session or result scan is active.
- vote_ack, output, 1: one-cycle pulse when a vote is committed.
- reject, output, 1: one-cycle pulse on duplicate UID or multi-button press.
- timeout, output, 1: one-cycle pulse when a session expires.
- sel_count, output, CNT_W: tally of candidate res_sel; 0 while mode = 0.
- total_votes, output, CNT_W: total votes committed (saturating).
- winner, output, clog2(NUM_CAND): index of the leading candidate.
- tie, output, 1: two or more candidates share the maximum tally.
- result_valid, output, 1: winner and tie are valid.

Behaviour:
- Reset (asynchronous):
  - All tallies, total_votes and the voted bitmap are cleared to 0.
  - State = IDLE.
  - All pulse outputs, busy, winner, tie, result_valid and sel_count = 0.
  - Edge-detect registers are loaded with 0, so a button held high through reset release registers as an edge on the first clock.
- States: IDLE, WAIT_VOTE, COMMIT, SCAN, SHOW.
- IDLE (mode = 0):
  - Rising edge of enter with voted[uid] = 1: pulse reject, stay in IDLE.
  - Rising edge of enter with voted[uid] = 0: latch uid, clear the timeout counter, go to WAIT_VOTE.
- WAIT_VOTE (busy = 1):
  - Exactly one cand_btn rising edge in a cycle: latch its index, go to COMMIT.
  - More than one rising edge in the same cycle: pulse reject, return to IDLE. The UID is not marked as voted.
  - Timeout counter reaches TIMEOUT_CYC-1 with no valid press: pulse timeout, return to IDLE. The UID is not marked.
  - enter edges are ignored in this state.
- COMMIT (one cycle):
  - Increment the selected tally, saturating at 2^CNT_W-1.
  - Increment total_votes, saturating independently.
  - Set voted[uid].
  - Pulse vote_ack and return to IDLE.
  - Vote latency: from button edge to vote_ack is 2 cycles.
- Mode = 1 asserted in IDLE or WAIT_VOTE:
  - Abort any open session with no vote recorded and no pulse.
  - Go to SCAN and clear result_valid.
  - COMMIT always completes before the mode change is honoured.
- SCAN (busy = 1):
  - One candidate is compared per cycle, index 0 up to NUM_CAND-1, so the scan takes NUM_CAND cycles.
  - A strictly greater tally replaces the running max and winner, and clears tie.
  - An equal tally sets tie. The lowest index is kept as winner.
  - All tallies equal 0: winner = 0, tie = 1 (when NUM_CAND >= 2).
  - At the end of the scan go to SHOW and set result_valid = 1.
- SHOW:
  - sel_count = tally[res_sel], registered with 1-cycle latency.
  - res_sel >= NUM_CAND gives sel_count = 0.
  - Candidate buttons and enter are ignored.
- Mode = 0 in SCAN or SHOW: go to IDLE, clear result_valid; tallies are retained.
- Reset asserted mid-session or mid-scan: immediate return to the reset state; no partial commit.
- The voted bitmap is never cleared except by reset.

Test Plan:
- Reset, then uid = 5, enter, cand_btn = 0010 -> vote_ack exactly 2 cycles after the button edge; tally[1] = 1; total_votes = 1.
- uid = 5 enters again -> reject pulse, no state change; uid = 6 votes cand 3 -> tally[3] = 1, total_votes = 2.
- uid = 7, enter, then cand_btn = 0011 in the same cycle -> reject; tallies unchanged; uid 7 can then vote successfully.
- uid = 9, enter, no button for TIMEOUT_CYC cycles -> timeout pulse at cycle TIMEOUT_CYC; uid 9 can still vote afterwards.
- Tallies {2,3,3,0}, mode = 1 -> result_valid after NUM_CAND cycles; winner = 1, tie = 1; res_sel = 2 gives sel_count = 3.
- CNT_W = 2, four votes for cand 0 -> tally[0] = 3 and total_votes = 3 (saturated); reset asserted while in WAIT_VOTE -> all outputs 0 on the same edge.
